rope_collision_ctrl: RTL and testbench
======================================

Name: rope_collision_ctrl

Overview:
- Per-frame collision controller directly upstream of the rope display array; produces that array's dirToggle and monkeyCollision inputs.
- Consumes the per-rope drawing requests, the monkey drawing request, VGA pixel coordinates and the signed rope speeds.
- Accumulates pixel-level hits during a frame, then issues one-cycle direction-toggle pulses and frame-long monkey-contact levels after startOfFrame.

Parameters:
- ROPES, 6, total rope count; bit i maps to rope i.
- LEFT_ROPES, 3, ropes 0..LEFT_ROPES-1 are confined to the left zone, the rest to the right zone.
- LEFT_WALL_X, 16, left wall of the left zone (inclusive).
- DIVIDER_X, 320, boundary between zones; left zone is < DIVIDER_X, right zone is >= DIVIDER_X.
- RIGHT_WALL_X, 623, right wall of the right zone (inclusive).
- COOLDOWN_FRAMES, 4, frames during which a rope ignores wall hits after it toggles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse marking frame start.
- pixelX  in  11  current VGA column.
- pixelY  in  11  current VGA row (unused by logic; kept for port compatibility).
- ropeDR  in  ROPES  per-rope drawing request.
- monkeyDR  in  1  monkey drawing request.
- SIGNED_SPEEDS  in  ROPES x 32  signed X speed per rope; bit 31 = 1 means moving left.
- dirToggle  out  ROPES  one-cycle toggle pulse per rope.
- monkeyCollision  out  ROPES  level, asserted for the whole frame after a contact.
- anyMonkeyCollision  out  1  OR of monkeyCollision.

Behaviour:
- Reset: all accumulators, hit registers, cooldown counters, dirToggle, monkeyCollision and anyMonkeyCollision are 0. Every rope's FSM is in ARMED.
- Wall hit for left rope i: ropeDR[i] && (pixelX <= LEFT_WALL_X || pixelX >= DIVIDER_X-1).
- Wall hit for right rope i: ropeDR[i] && (pixelX <= DIVIDER_X || pixelX >= RIGHT_WALL_X).
- Wall side: low wall = left wall / divider on the low side; high wall = the other side. A separate sticky flag is kept per side: wallLo[i], wallHi[i].
- Monkey hit: ropeDR[i] && monkeyDR sets a sticky flag monk[i].
- Accumulation: flags are ORed every cycle. A hit on the same cycle as startOfFrame belongs to the closing frame.
- On startOfFrame:
  - Accumulated flags are copied into frame registers, then accumulators clear.
  - Evaluation happens on the next cycle (cycle F+1).
  - Outputs update at the end of F+1, so they are visible from cycle F+2.
  - Latency from frame start to dirToggle pulse is 2 cycles.
- Per-rope FSM:
  - ARMED:
    - Toggle if (wallLo && speed negative) || (wallHi && speed non-negative), i.e. only when the rope moves toward the wall it touched.
    - On toggle: pulse dirToggle[i] for exactly 1 cycle, load cooldown = COOLDOWN_FRAMES, go to COOLDOWN.
    - Wall hits with the rope moving away are ignored; the FSM stays ARMED.
  - COOLDOWN:
    - Decrement the counter once per startOfFrame evaluation.
    - Wall hits are ignored.
    - Go to ARMED when the counter reaches 0.
    - With COOLDOWN_FRAMES = 0, the FSM returns to ARMED on the next evaluation.
- Counter width is $clog2(COOLDOWN_FRAMES+1), minimum 1 bit. Decrement saturates at 0.
- monkeyCollision[i]:
  - Set to the frame register monk[i] at evaluation and held until the next evaluation.
  - It is independent of the FSM and cooldown state.
- Zero-speed rope: treated as moving right, so only a high-wall hit toggles it.
- Both wall flags set in one frame: the speed-sign rule decides; at most one toggle per rope per frame.
- Reset mid-frame: everything clears immediately; the partial frame's hits are discarded.
- Two startOfFrame pulses 1 cycle apart: the second pulse evaluates an empty frame (no toggles) and decrements cooldown normally.

Optional Feature:
- Macro: ROPE_ROPE_COLLISION_EN.
- Defined:
  - A cycle with two or more ropeDR bits set within the same zone sets the rrHit flag for each rope involved.
  - At evaluation, an ARMED rope with rrHit toggles, using the same pulse and cooldown path as a wall toggle.
  - This applies regardless of speed sign.
- Undefined: rope-rope overlap is ignored; no extra logic is synthesized.

Decomposition:
- Shared package rope_pkg holds:
  - ROPES and LEFT_ROPES defaults, the wall/divider constants and COOLDOWN_FRAMES;
  - typedef rope_state_t enum {ARMED, COOLDOWN};
  - typedef rope_speed_t logic signed [31:0].
- Natural sub-module rope_bounce_fsm: one instance per rope, generated.
  - Inputs: wallLo, wallHi, rrHit, speed sign, eval strobe.
  - Outputs: dirToggle, state.
- The top level holds the accumulators, the zone decode and the monkey logic.

Test Plan:
- Reset asserted mid-frame with accumulated hits -> all outputs 0 within the reset cycle; the next startOfFrame produces no toggle.
- Rope 0, speed -3, ropeDR[0]=1 at pixelX=10, then startOfFrame at cycle T -> dirToggle = 6'b000001 at T+2 only; no toggle on the following 4 frames despite repeated hits; a toggle is possible again on the 5th.
- Rope 4, speed +5, ropeDR[4] at pixelX=623 -> dirToggle[4] pulses. Same hit with speed -5 -> no pulse, FSM stays ARMED.
- monkeyDR && ropeDR[2] at pixelX=200 in frame N -> monkeyCollision = 6'b000100 and anyMonkeyCollision = 1 for all of frame N+1; cleared after frame N+1's evaluation when there is no contact.
- Wall hit on the same cycle as startOfFrame -> counted in the closing frame; dirToggle 2 cycles later.
- With ROPE_ROPE_COLLISION_EN: ropeDR = 6'b000011 at pixelX=150 -> dirToggle = 6'b000011. Without the macro -> 6'b000000.

Source files
------------

// File: rtl/rope_pkg.sv
// Shared constants and types for the rope collision controller and its per-rope bounce FSM.
// Optional rope-rope overlap detection is enabled by defining ROPE_ROPE_COLLISION_EN.
package rope_pkg;

   localparam int DEF_ROPES           = 6;
   localparam int DEF_LEFT_ROPES      = 3;
   localparam int DEF_LEFT_WALL_X     = 16;
   localparam int DEF_DIVIDER_X       = 320;
   localparam int DEF_RIGHT_WALL_X    = 623;
   localparam int DEF_COOLDOWN_FRAMES = 4;

   typedef enum logic {
      ARMED    = 1'b0,
      COOLDOWN = 1'b1
   } rope_state_t;

   typedef logic signed [31:0] rope_speed_t;

   // A cooldown of zero frames still needs a one-bit counter.
   function automatic int cnt_width(input int frames);
      return (frames > 0) ? $clog2(frames + 1) : 1;
   endfunction

endpackage

// File: rtl/rope_bounce_fsm.sv
// Per-rope bounce FSM: turns one frame's accumulated hits into a single direction-toggle
// pulse, then ignores further hits for a configurable number of frames.
module rope_bounce_fsm
   import rope_pkg::*;
#(
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_eval,
   input  logic        i_wall_lo,
   input  logic        i_wall_hi,
   input  logic        i_rr_hit,
   input  logic        i_speed_neg,
   output logic        o_dir_toggle,
   output rope_state_t o_state
);

   localparam int               CNT_W    = cnt_width(COOLDOWN_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rope_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_toggle;
   logic             w_toward;

   // Only a wall the rope is moving toward counts; zero speed counts as moving right.
   assign w_toward = (i_wall_lo && i_speed_neg) || (i_wall_hi && !i_speed_neg) || i_rr_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ARMED;
         r_cnt    <= '0;
         r_toggle <= 1'b0;
      end else begin
         // NOTE: default-clearing the toggle each cycle is what limits it to a single-cycle pulse.
         r_toggle <= 1'b0;
         if (i_eval) begin
            case (r_state)
               ARMED: begin
                  if (w_toward) begin
                     r_toggle <= 1'b1;
                     r_cnt    <= CNT_LOAD;
                     r_state  <= COOLDOWN;
                  end
               end
               COOLDOWN: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - CNT_ONE;
                  end
                  if ((r_cnt == '0) || (r_cnt == CNT_ONE)) begin
                     r_state <= ARMED;
                  end
               end
               default: r_state <= ARMED;
            endcase
         end
      end
   end

   assign o_dir_toggle = r_toggle;
   assign o_state      = r_state;

endmodule

// File: rtl/rope_collision_ctrl.sv
// Per-frame rope collision controller: accumulates wall/monkey hits over a frame and evaluates
// them one cycle after startOfFrame. Define ROPE_ROPE_COLLISION_EN to add rope-rope bounces.
module rope_collision_ctrl
   import rope_pkg::*;
#(
   parameter int ROPES           = DEF_ROPES,
   parameter int LEFT_ROPES      = DEF_LEFT_ROPES,
   parameter int LEFT_WALL_X     = DEF_LEFT_WALL_X,
   parameter int DIVIDER_X       = DEF_DIVIDER_X,
   parameter int RIGHT_WALL_X    = DEF_RIGHT_WALL_X,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    startOfFrame,
   input  logic [10:0]             pixelX,
   input  logic [10:0]             pixelY,
   input  logic [ROPES-1:0]        ropeDR,
   input  logic                    monkeyDR,
   input  rope_speed_t [ROPES-1:0] SIGNED_SPEEDS,
   output logic [ROPES-1:0]        dirToggle,
   output logic [ROPES-1:0]        monkeyCollision,
   output logic                    anyMonkeyCollision
);

   localparam logic [10:0] C_LEFT_WALL  = 11'(LEFT_WALL_X);
   localparam logic [10:0] C_DIV_LO     = 11'(DIVIDER_X - 1);
   localparam logic [10:0] C_DIV        = 11'(DIVIDER_X);
   localparam logic [10:0] C_RIGHT_WALL = 11'(RIGHT_WALL_X);

   logic [ROPES-1:0]        w_lo_hit, w_hi_hit, w_monk_hit, w_speed_neg, w_rr_frm;
   logic [ROPES-1:0]        r_lo_acc, r_hi_acc, r_monk_acc;
   logic [ROPES-1:0]        r_lo_frm, r_hi_frm, r_monk_frm;
   logic [ROPES-1:0]        r_monk_out;
   logic                    r_any_monk;
   logic                    r_eval;
   rope_state_t [ROPES-1:0] w_state;
   logic                    w_unused;

   always_comb begin
      w_lo_hit    = '0;
      w_hi_hit    = '0;
      w_speed_neg = '0;
      for (int i = 0; i < ROPES; i++) begin
         w_speed_neg[i] = SIGNED_SPEEDS[i][31];
         if (i < LEFT_ROPES) begin
            w_lo_hit[i] = ropeDR[i] && (pixelX <= C_LEFT_WALL);
            w_hi_hit[i] = ropeDR[i] && (pixelX >= C_DIV_LO);
         end else begin
            w_lo_hit[i] = ropeDR[i] && (pixelX <= C_DIV);
            w_hi_hit[i] = ropeDR[i] && (pixelX >= C_RIGHT_WALL);
         end
      end
   end

   assign w_monk_hit = ropeDR & {ROPES{monkeyDR}};

   // A hit on the startOfFrame cycle is folded into the frame that is closing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lo_acc   <= '0;
         r_hi_acc   <= '0;
         r_monk_acc <= '0;
         r_lo_frm   <= '0;
         r_hi_frm   <= '0;
         r_monk_frm <= '0;
         r_eval     <= 1'b0;
      end else begin
         r_eval <= startOfFrame;
         if (startOfFrame) begin
            r_lo_frm   <= r_lo_acc | w_lo_hit;
            r_hi_frm   <= r_hi_acc | w_hi_hit;
            r_monk_frm <= r_monk_acc | w_monk_hit;
            r_lo_acc   <= '0;
            r_hi_acc   <= '0;
            r_monk_acc <= '0;
         end else begin
            r_lo_acc   <= r_lo_acc | w_lo_hit;
            r_hi_acc   <= r_hi_acc | w_hi_hit;
            r_monk_acc <= r_monk_acc | w_monk_hit;
         end
      end
   end

`ifdef ROPE_ROPE_COLLISION_EN
   localparam logic [ROPES-1:0] C_LEFT_MASK = ROPES'((64'd1 << LEFT_ROPES) - 64'd1);

   logic [ROPES-1:0] w_rr_hit, r_rr_acc, r_rr_frm;

   always_comb begin
      w_rr_hit = '0;
      if ($countones(ropeDR & C_LEFT_MASK) >= 2) begin
         w_rr_hit = w_rr_hit | (ropeDR & C_LEFT_MASK);
      end
      if ($countones(ropeDR & ~C_LEFT_MASK) >= 2) begin
         w_rr_hit = w_rr_hit | (ropeDR & ~C_LEFT_MASK);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_acc <= '0;
         r_rr_frm <= '0;
      end else if (startOfFrame) begin
         r_rr_frm <= r_rr_acc | w_rr_hit;
         r_rr_acc <= '0;
      end else begin
         r_rr_acc <= r_rr_acc | w_rr_hit;
      end
   end

   assign w_rr_frm = r_rr_frm;
`else
   assign w_rr_frm = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_monk_out <= '0;
         r_any_monk <= 1'b0;
      end else if (r_eval) begin
         r_monk_out <= r_monk_frm;
         r_any_monk <= |r_monk_frm;
      end
   end

   for (genvar g = 0; g < ROPES; g++) begin : g_rope
      rope_bounce_fsm #(
         .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
      ) u_fsm (
         .clk          (clk),
         .reset        (reset),
         .i_eval       (r_eval),
         .i_wall_lo    (r_lo_frm[g]),
         .i_wall_hi    (r_hi_frm[g]),
         .i_rr_hit     (w_rr_frm[g]),
         .i_speed_neg  (w_speed_neg[g]),
         .o_dir_toggle (dirToggle[g]),
         .o_state      (w_state[g])
      );
   end

   assign monkeyCollision    = r_monk_out;
   assign anyMonkeyCollision = r_any_monk;

   // pixelY, the speed magnitudes and the FSM states are not needed by this block's logic.
   assign w_unused = ^{pixelY, SIGNED_SPEEDS, w_state};

endmodule

// File: tb/tb_rope_collision_ctrl.sv
// Self-checking bench for rope_collision_ctrl: directed scenarios plus randomized frames,
// compared against a frame-level behavioural model of the collision rules.
module tb_rope_collision_ctrl;
   import rope_pkg::*;

   localparam int R  = DEF_ROPES;
   localparam int LR = DEF_LEFT_ROPES;

   logic                clk = 1'b0;
   logic                reset;
   logic                startOfFrame;
   logic [10:0]         pixelX;
   logic [10:0]         pixelY;
   logic [R-1:0]        ropeDR;
   logic                monkeyDR;
   rope_speed_t [R-1:0] speeds;
   logic [R-1:0]        dirToggle;
   logic [R-1:0]        monkeyCollision;
   logic                anyMonkeyCollision;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Model state: per-frame sticky flags, frames of cooldown left, last expected monkey level.
   bit [R-1:0] m_lo, m_hi, m_mk, m_mon;
   int         m_cool [R];
`ifdef ROPE_ROPE_COLLISION_EN
   bit [R-1:0] m_rr;
`endif

   int xs [12] = '{0, 10, 16, 17, 150, 200, 318, 319, 320, 321, 622, 623};

   rope_collision_ctrl dut (
      .clk                (clk),
      .reset              (reset),
      .startOfFrame       (startOfFrame),
      .pixelX             (pixelX),
      .pixelY             (pixelY),
      .ropeDR             (ropeDR),
      .monkeyDR           (monkeyDR),
      .SIGNED_SPEEDS      (speeds),
      .dirToggle          (dirToggle),
      .monkeyCollision    (monkeyCollision),
      .anyMonkeyCollision (anyMonkeyCollision)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [R-1:0] obs, input logic [R-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_lo  = '0;
      m_hi  = '0;
      m_mk  = '0;
      m_mon = '0;
      for (int i = 0; i < R; i++) m_cool[i] = 0;
`ifdef ROPE_ROPE_COLLISION_EN
      m_rr = '0;
`endif
   endfunction

   function automatic void m_cycle(input logic [R-1:0] dr, input int x, input logic mk);
      int nl = 0;
      int nr = 0;
      for (int i = 0; i < R; i++) begin
         if (dr[i]) begin
            if (i < LR) begin
               if (x <= DEF_LEFT_WALL_X)   m_lo[i] = 1'b1;
               if (x >= DEF_DIVIDER_X - 1) m_hi[i] = 1'b1;
               nl++;
            end else begin
               if (x <= DEF_DIVIDER_X)    m_lo[i] = 1'b1;
               if (x >= DEF_RIGHT_WALL_X) m_hi[i] = 1'b1;
               nr++;
            end
            if (mk) m_mk[i] = 1'b1;
         end
      end
`ifdef ROPE_ROPE_COLLISION_EN
      for (int i = 0; i < R; i++) begin
         if (dr[i] && ((i < LR && nl >= 2) || (i >= LR && nr >= 2))) m_rr[i] = 1'b1;
      end
`endif
   endfunction

   // Closes a frame in the model: returns the toggles the frame should produce.
   function automatic logic [R-1:0] m_eval();
      logic [R-1:0] t = '0;
      for (int i = 0; i < R; i++) begin
         bit moving_left = (speeds[i] < 0);
         bit bounce = (m_lo[i] && moving_left) || (m_hi[i] && !moving_left);
`ifdef ROPE_ROPE_COLLISION_EN
         bounce = bounce || m_rr[i];
`endif
         if (m_cool[i] > 0) begin
            m_cool[i]--;
         end else if (bounce) begin
            t[i]      = 1'b1;
            m_cool[i] = DEF_COOLDOWN_FRAMES;
         end
      end
      m_mon = m_mk;
      m_lo  = '0;
      m_hi  = '0;
      m_mk  = '0;
`ifdef ROPE_ROPE_COLLISION_EN
      m_rr = '0;
`endif
      return t;
   endfunction

   task automatic drive(input logic [R-1:0] dr, input int x, input logic mk);
      ropeDR       = dr;
      pixelX       = 11'(x);
      pixelY       = 11'($urandom_range(0, 479));
      monkeyDR     = mk;
      startOfFrame = 1'b0;
      m_cycle(dr, x, mk);
      @(posedge clk);
      #1;
   endtask

   task automatic close_frame(input string tag, input logic [R-1:0] dr, input int x, input logic mk);
      logic [R-1:0] exp_t;
      ropeDR       = dr;
      pixelX       = 11'(x);
      monkeyDR     = mk;
      startOfFrame = 1'b1;
      m_cycle(dr, x, mk);
      exp_t = m_eval();
      @(posedge clk);
      #1;
      startOfFrame = 1'b0;
      ropeDR       = '0;
      monkeyDR     = 1'b0;
      check({tag, "_lat1"}, dirToggle, '0);
      drive('0, 0, 1'b0);
      check({tag, "_toggle"}, dirToggle, exp_t);
      check({tag, "_monk"}, monkeyCollision, m_mon);
      check({tag, "_any"}, R'(anyMonkeyCollision), R'(|m_mon));
      drive('0, 0, 1'b0);
      check({tag, "_pulse_end"}, dirToggle, '0);
   endtask

   task automatic idle_frames(input int n);
      for (int k = 0; k < n; k++) begin
         drive('0, 0, 1'b0);
         close_frame("idle", '0, 0, 1'b0);
      end
   endtask

   function automatic logic [R-1:0] rand_dr();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return R'(1 << $urandom_range(0, R - 1));
         2:       return R'($urandom) & R'($urandom);
         default: return R'($urandom);
      endcase
   endfunction

   function automatic rope_speed_t rand_speed();
      case ($urandom_range(0, 2))
         0:       return rope_speed_t'(-int'($urandom_range(1, 9)));
         1:       return '0;
         default: return rope_speed_t'($urandom_range(1, 9));
      endcase
   endfunction

   initial begin
      logic [R-1:0] exp1, exp2;
      reset        = 1'b1;
      startOfFrame = 1'b0;
      pixelX       = '0;
      pixelY       = '0;
      ropeDR       = '0;
      monkeyDR     = 1'b0;
      for (int i = 0; i < R; i++) speeds[i] = 1;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_toggle", dirToggle, '0);
      check("rst_monk", monkeyCollision, '0);
      check("rst_any", R'(anyMonkeyCollision), '0);
      reset = 1'b0;
      drive('0, 0, 1'b0);

      // Rope 0 moving left hits the left wall, then sits out four frames.
      speeds[0] = -3;
      drive(6'b000001, 10, 1'b0);
      close_frame("r0_hit", '0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(6'b000001, 10, 1'b0);
         close_frame("r0_cool", '0, 0, 1'b0);
      end
      drive(6'b000001, 10, 1'b0);
      close_frame("r0_rearm", '0, 0, 1'b0);

      // Rope 4 at the right wall: bounces only when moving toward it.
      speeds[4] = 5;
      drive(6'b010000, 623, 1'b0);
      close_frame("r4_pos", '0, 0, 1'b0);
      idle_frames(5);
      speeds[4] = -5;
      drive(6'b010000, 623, 1'b0);
      close_frame("r4_neg", '0, 0, 1'b0);
      speeds[4] = 5;
      drive(6'b010000, 623, 1'b0);
      close_frame("r4_armed", '0, 0, 1'b0);

      // Monkey contact on rope 2 holds for the next frame, then clears.
      drive(6'b000100, 200, 1'b1);
      close_frame("monk_set", '0, 0, 1'b0);
      repeat (4) drive('0, 0, 1'b0);
      check("monk_hold", monkeyCollision, m_mon);
      check("monk_hold_any", R'(anyMonkeyCollision), R'(|m_mon));
      close_frame("monk_clr", '0, 0, 1'b0);

      // Reset in the middle of a frame that already holds hits.
      drive(6'b000100, 200, 1'b1);
      close_frame("monk_again", '0, 0, 1'b0);
      idle_frames(4);
      drive(6'b000100, 200, 1'b1);
      close_frame("monk_pre_rst", '0, 0, 1'b0);
      speeds[0] = -3;
      drive(6'b000001, 10, 1'b0);
      drive(6'b010000, 623, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_monk", monkeyCollision, '0);
      check("rst_mid_any", R'(anyMonkeyCollision), '0);
      check("rst_mid_toggle", dirToggle, '0);
      m_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      close_frame("post_rst", '0, 0, 1'b0);

      // Hit on the startOfFrame cycle belongs to the closing frame.
      speeds[1] = 2;
      close_frame("sof_same", 6'b000010, 319, 1'b0);

      // Zero speed counts as moving right.
      speeds[3] = 0;
      drive(6'b001000, 320, 1'b0);
      close_frame("zero_lo", '0, 0, 1'b0);
      drive(6'b001000, 630, 1'b0);
      close_frame("zero_hi", '0, 0, 1'b0);

      // Both walls in one frame: sign picks, one toggle at most.
      speeds[5] = -1;
      drive(6'b100000, 320, 1'b0);
      drive(6'b100000, 623, 1'b0);
      close_frame("both_walls", '0, 0, 1'b0);

      // Two ropes overlapping in the left zone away from any wall.
      idle_frames(5);
      for (int i = 0; i < R; i++) speeds[i] = 1;
      drive(6'b000011, 150, 1'b0);
      close_frame("rope_rope", '0, 0, 1'b0);

      // Back-to-back startOfFrame pulses: the second frame is empty.
      idle_frames(5);
      speeds[0] = -3;
      drive(6'b000001, 10, 1'b0);
      ropeDR       = '0;
      startOfFrame = 1'b1;
      m_cycle('0, 0, 1'b0);
      exp1 = m_eval();
      @(posedge clk);
      #1;
      m_cycle('0, 0, 1'b0);
      exp2 = m_eval();
      @(posedge clk);
      #1;
      check("b2b_first", dirToggle, exp1);
      startOfFrame = 1'b0;
      @(posedge clk);
      #1;
      check("b2b_second", dirToggle, exp2);
      for (int k = 0; k < 4; k++) begin
         drive(6'b000001, 10, 1'b0);
         close_frame("b2b_cool", '0, 0, 1'b0);
      end

      // Randomized frames.
      for (int f = 0; f < 60; f++) begin
         for (int i = 0; i < R; i++) speeds[i] = rand_speed();
         repeat ($urandom_range(2, 8)) begin
            drive(rand_dr(), xs[$urandom_range(0, 11)], ($urandom_range(0, 7) == 0));
         end
         close_frame("rand", rand_dr(), xs[$urandom_range(0, 11)], ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
